mix128_sched: RTL and testbench
===============================

Name: mix128_sched

Overview:
- Round-robin scheduler that shares one Mix128 engine among NREQ independent requesters, e.g. parallel DryGASCON lanes.
- Accepts one job per valid/ready handshake and latches its operands (c, x, i, ds).
- Sequences the engine through clear, start and wait, then returns the mixed state with the requester id on a valid/ready response port.
- Sits between the lane controllers and a single Mix128 instance.

Parameters:
- NREQ, 4, number of requesters (≥2).
- CWIDTH, 256, state width; must match the engine.
- XWORDS32, 4, x width in 32-bit words.
- DS_WIDTH, 128, domain-separator width.
- TIMEOUT, 4096, watchdog limit in cycles (used only with MIX_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester job request
- req_ready  out  NREQ  one-hot grant/accept
- req_c  in  NREQ*CWIDTH  flattened per-requester state (slot k at [k*CWIDTH +: CWIDTH])
- req_x  in  NREQ*XWORDS32*32  flattened per-requester x
- req_i  in  NREQ*128  flattened per-requester i
- req_ds  in  NREQ*DS_WIDTH  flattened per-requester ds
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ)  requester index of the result
- rsp_c  out  CWIDTH  mixed state
- mix_reset  out  1  engine reset (also driven by reset)
- mix_en  out  1  engine enable
- mix_c, mix_x, mix_i, mix_ds  out  engine widths  latched operands
- mix_done  in  1  engine done (level; stays high until the engine is reset)
- mix_cout  in  CWIDTH  engine result, valid while mix_done=1
- rsp_err  out  1  watchdog abort flag (macro only)

Behaviour:
- Reset is synchronous, active-high on clk. During reset:
  - all state goes to IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_c=0; operand registers=0; mix_en=0.
  - last_grant = NREQ-1, so requester 0 wins first.
- mix_reset = reset | (state==CLEAR). It is combinational, so the engine is held in reset throughout any global reset.
- FSM states: IDLE, CLEAR, START, WAIT, RESP.
  - IDLE: if any req_valid, grant g = first set bit searching upward from last_grant+1, with wrap.
    - req_ready[g]=1 in the same cycle; operands of slot g latched at the clock edge.
    - Also latched: cur_id=g, last_grant=g. Next state CLEAR.
    - No req_valid: stay in IDLE.
  - CLEAR: mix_reset=1 for exactly one cycle; -> START.
  - START: mix_en=1; -> WAIT.
  - WAIT: mix_en stays 1.
    - On mix_done=1: rsp_c<=mix_cout, rsp_id<=cur_id; -> RESP.
  - RESP: rsp_valid=1; rsp_c and rsp_id held stable.
    - On rsp_ready=1: -> IDLE, with rsp_valid low the next cycle.
    - The engine is not reset here; CLEAR of the next job does it.
- req_ready is zero in every state except IDLE, and at most one bit is ever set.
- mix_* operands change only on an IDLE accept; they are stable from CLEAR through RESP.
- Latency: accept at cycle t, mix_reset at t+1, mix_en rises at t+2, rsp_valid one cycle after mix_done is first sampled high.
- A requester that drops req_valid before a grant is simply skipped. The bench must not rely on req_valid being held, although a held req_valid is legal.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0,…
- Reset mid-job: job discarded, no response issued, engine reset via mix_reset.
- A spurious mix_done outside WAIT is ignored.

Optional Feature:
- Macro MIX_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on START and increments in WAIT.
  - If it reaches TIMEOUT without mix_done: go to RESP with rsp_c=0 and rsp_err=1.
  - rsp_err is 0 for normal completions and resets to 0.
- Undefined: no counter; rsp_err port absent; WAIT waits indefinitely.

Decomposition:
- Package mix_sched_pkg holds:
  - the sched_state_t enum {IDLE, CLEAR, START, WAIT, RESP};
  - the function rr_next(req, last) returning the grant index;
  - the localparam ID_W = $clog2(NREQ).
- One natural combinational sub-module: mix_rr_pick (inputs req_valid, last_grant; outputs gnt_onehot, gnt_idx, any). It is reusable for other shared engines.

Test Plan:
- Single job: reset, then req_valid=4'b0100 with c=256'h1, and a stub engine asserting mix_done 10 cycles after mix_en with mix_cout=c+1.
  - Expect req_ready=4'b0100 for one cycle, mix_reset one cycle later, rsp_id=2, rsp_c=256'h2.
- All four requesters held valid for 8 jobs with rsp_ready=1 → grant order 0,1,2,3,0,1,2,3; no overlapping req_ready.
- Back-pressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_c/rsp_id stable, no new req_ready; release → IDLE and next grant.
- Reset asserted 3 cycles into WAIT → no response, mix_reset high during reset; next grant goes to requester 0.
- With the macro defined and TIMEOUT=16, stub never asserts mix_done → rsp_valid at START+17 with rsp_err=1, rsp_c=0.
- Mix128 integration: cross-check rsp_c against a software model for a known (c, x, i, ds) vector on two requesters back-to-back; the second result must be unaffected by the first (verifies CLEAR).

Source files
------------

// File: rtl/mix_sched_pkg.sv
// Shared types and the round-robin search used by the Mix128 job scheduler.
package mix_sched_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RESP} sched_state_t;

    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);
    localparam int RR_MAX   = 32;

    // First set bit of req searching upward from last+1 with wrap over n slots;
    // returns last when nothing is requested.
    function automatic int rr_next(input logic [RR_MAX-1:0] req, input int last, input int n);
        int idx;
        rr_next = last;
        for (int k = RR_MAX; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mix_rr_pick.sv
// Combinational round-robin picker: one-hot and index grant after last_grant.
module mix_rr_pick
    import mix_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [RR_MAX-1:0] w_req;
    int                w_idx;

    always_comb begin
        w_req             = '0;
        w_req[NREQ-1:0]   = req_valid;
        w_idx             = rr_next(w_req, int'(last_grant), NREQ);
        any               = |req_valid;
        gnt_idx           = IDW'(w_idx);
        gnt_onehot        = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mix128_sched.sv
// Round-robin scheduler sharing one Mix128 engine among NREQ requesters.
// Optional watchdog abort enabled by defining MIX_SCHED_TIMEOUT_EN.
module mix128_sched
    import mix_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CWIDTH   = 256,
    parameter int XWORDS32 = 4,
    parameter int DS_WIDTH = 128,
    parameter int TIMEOUT  = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*CWIDTH-1:0]       req_c,
    input  logic [NREQ*XWORDS32*32-1:0]  req_x,
    input  logic [NREQ*128-1:0]          req_i,
    input  logic [NREQ*DS_WIDTH-1:0]     req_ds,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic [CWIDTH-1:0]            rsp_c,
    output logic                         mix_reset,
    output logic                         mix_en,
    output logic [CWIDTH-1:0]            mix_c,
    output logic [XWORDS32*32-1:0]       mix_x,
    output logic [127:0]                 mix_i,
    output logic [DS_WIDTH-1:0]          mix_ds,
    input  logic                         mix_done,
`ifdef MIX_SCHED_TIMEOUT_EN
    input  logic [CWIDTH-1:0]            mix_cout,
    output logic                         rsp_err
`else
    input  logic [CWIDTH-1:0]            mix_cout
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int XW  = XWORDS32 * 32;

    sched_state_t r_state, w_next;

    logic [IDW-1:0]      r_last_grant, r_cur_id, r_rsp_id, w_gnt_idx;
    logic [NREQ-1:0]     w_gnt_onehot;
    logic                w_any;
    logic [CWIDTH-1:0]   r_c, r_rsp_c, w_sel_c;
    logic [XW-1:0]       r_x, w_sel_x;
    logic [127:0]        r_i, w_sel_i;
    logic [DS_WIDTH-1:0] r_ds, w_sel_ds;

`ifdef MIX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_expired;
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_err   = r_err;
`endif

    mix_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_valid  (req_valid),
        .last_grant (r_last_grant),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // Operand mux driven by the one-hot grant so every slice is a constant select.
    always_comb begin
        w_sel_c  = '0;
        w_sel_x  = '0;
        w_sel_i  = '0;
        w_sel_ds = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_onehot[k]) begin
                w_sel_c  = req_c[k*CWIDTH +: CWIDTH];
                w_sel_x  = req_x[k*XW +: XW];
                w_sel_i  = req_i[k*128 +: 128];
                w_sel_ds = req_ds[k*DS_WIDTH +: DS_WIDTH];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_any) w_next = CLEAR;
            CLEAR: w_next = START;
            START: w_next = WAIT;
            WAIT: begin
                if (mix_done) w_next = RESP;
`ifdef MIX_SCHED_TIMEOUT_EN
                else if (w_expired) w_next = RESP;
`endif
            end
            RESP:  if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_cur_id     <= '0;
            r_rsp_id     <= '0;
            r_rsp_c      <= '0;
            r_c          <= '0;
            r_x          <= '0;
            r_i          <= '0;
            r_ds         <= '0;
`ifdef MIX_SCHED_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_c          <= w_sel_c;
                        r_x          <= w_sel_x;
                        r_i          <= w_sel_i;
                        r_ds         <= w_sel_ds;
                        r_cur_id     <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                    end
                end
`ifdef MIX_SCHED_TIMEOUT_EN
                START: r_cnt <= '0;
`endif
                WAIT: begin
                    if (mix_done) begin
                        r_rsp_c  <= mix_cout;
                        r_rsp_id <= r_cur_id;
`ifdef MIX_SCHED_TIMEOUT_EN
                        r_err    <= 1'b0;
                    end else if (w_expired) begin
                        r_rsp_c  <= '0;
                        r_rsp_id <= r_cur_id;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are forced quiet while reset is held.
    assign req_ready = (!reset && r_state == IDLE) ? w_gnt_onehot : '0;
    assign rsp_valid = !reset && (r_state == RESP);
    assign mix_en    = !reset && (r_state == START || r_state == WAIT);
    assign mix_reset = reset | (r_state == CLEAR);
    assign rsp_id    = r_rsp_id;
    assign rsp_c     = r_rsp_c;
    assign mix_c     = r_c;
    assign mix_x     = r_x;
    assign mix_i     = r_i;
    assign mix_ds    = r_ds;

endmodule

// File: tb/tb_mix128_sched.sv
// Directed bench for mix128_sched with a stub engine that finishes 10 cycles after mix_en.
module tb_mix128_sched;

    localparam int NREQ = 4;
    localparam int CW   = 256;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*CW-1:0]   req_c;
    logic [NREQ*128-1:0]  req_x, req_i, req_ds;
    logic                 rsp_valid, rsp_ready;
    logic [1:0]           rsp_id;
    logic [CW-1:0]        rsp_c, mix_c, mix_cout;
    logic                 mix_reset, mix_en, mix_done;
    logic [127:0]         mix_x, mix_i, mix_ds;
`ifdef MIX_SCHED_TIMEOUT_EN
    logic                 rsp_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic stub_hang = 1'b0;
    logic [3:0] s_cnt;

    always #5 clk = ~clk;

    mix128_sched #(.NREQ(NREQ), .CWIDTH(CW), .XWORDS32(4), .DS_WIDTH(128), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_c(req_c), .req_x(req_x), .req_i(req_i), .req_ds(req_ds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .mix_reset(mix_reset), .mix_en(mix_en),
        .mix_c(mix_c), .mix_x(mix_x), .mix_i(mix_i), .mix_ds(mix_ds),
        .mix_done(mix_done),
`ifdef MIX_SCHED_TIMEOUT_EN
        .mix_cout(mix_cout), .rsp_err(rsp_err)
`else
        .mix_cout(mix_cout)
`endif
    );

    function automatic logic [255:0] fmix(input logic [255:0] c, input logic [127:0] x,
                                          input logic [127:0] i, input logic [127:0] ds);
        return c + {x, i} + {128'b0, ds} + 256'd1;
    endfunction

    // Stub engine: done level-high 10 cycles after mix_en, cleared only by mix_reset.
    always_ff @(posedge clk) begin
        if (mix_reset) begin
            s_cnt    <= '0;
            mix_done <= 1'b0;
            mix_cout <= '0;
        end else if (mix_en && !mix_done && !stub_hang) begin
            if (s_cnt == 4'd9) begin
                mix_done <= 1'b1;
                mix_cout <= fmix(mix_c, mix_x, mix_i, mix_ds);
            end else begin
                s_cnt <= s_cnt + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [255:0] c, input logic [127:0] x,
                            input logic [127:0] i, input logic [127:0] ds);
        req_c[k*CW +: CW]   = c;
        req_x[k*128 +: 128] = x;
        req_i[k*128 +: 128] = i;
        req_ds[k*128 +: 128] = ds;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        if (req_ready == '0) begin
            chk("grant_timeout", 1, 0);
        end else begin
            chk("grant_onehot", $countones(req_ready), 1);
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
        end
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (!rsp_valid) chk("rsp_timeout", 1, 0);
    endtask

    task automatic wait_mix_en();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mix_en) break;
        end
        if (!mix_en) chk("mix_en_timeout", 1, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        int g, lat, bad_stable, bad_ready, bad_valid, seen;
        logic [255:0] hold_c, exp1, exp2;
        logic [1:0]   hold_id;

        reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
        req_c = '0; req_x = '0; req_i = '0; req_ds = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_mix_en", mix_en, 0);
        chk("rst_mix_reset", mix_reset, 1);
        chk("rst_mix_c", mix_c, 0);
        @(posedge clk); #1 reset = 1'b0; req_valid = '0;

        // Single job on requester 2
        @(posedge clk); #1 set_slot(2, 256'h1, 0, 0, 0); req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0100);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t1_ready_drop", req_ready, 0);
        chk("t1_clear", mix_reset, 1);
        chk("t1_mix_c", mix_c, 256'h1);
        @(negedge clk);
        chk("t1_mix_en", mix_en, 1);
        chk("t1_clear_off", mix_reset, 0);
        lat = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); lat++;
            if (rsp_valid) break;
        end
        chk("t1_latency", lat, 11);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_c", rsp_c, 256'h2);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("t1_rsp_drop", rsp_valid, 0);

        // Fairness with all four held valid
        pulse_reset();
        for (int k = 0; k < NREQ; k++) set_slot(k, 256'(k + 10), 0, 0, 0);
        req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            wait_grant(g);
            chk("rr_order", g, j % 4);
        end
        @(posedge clk); #1 req_valid = '0;
        wait_rsp();
        chk("rr_last_rsp_id", rsp_id, 3);
        chk("rr_last_rsp_c", rsp_c, 256'd14);
        @(negedge clk);

        // Back-pressure
        @(posedge clk); #1 rsp_ready = 1'b0;
        set_slot(0, 256'h55, 0, 0, 0); set_slot(1, 256'h77, 0, 0, 0);
        req_valid = 4'b0011;
        wait_grant(g);
        chk("bp_grant", g, 0);
        wait_rsp();
        chk("bp_rsp_c", rsp_c, 256'h56);
        chk("bp_rsp_id", rsp_id, 0);
        hold_c = rsp_c; hold_id = rsp_id;
        bad_stable = 0; bad_ready = 0; bad_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_c !== hold_c || rsp_id !== hold_id) bad_stable++;
            if (req_ready != '0) bad_ready++;
            if (!rsp_valid) bad_valid++;
        end
        chk("bp_stable", bad_stable, 0);
        chk("bp_no_ready", bad_ready, 0);
        chk("bp_valid_held", bad_valid, 0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("bp_released", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp();
        chk("bp2_rsp_id", rsp_id, 1);
        chk("bp2_rsp_c", rsp_c, 256'h78);
        @(negedge clk);

        // Reset in the middle of WAIT
        @(posedge clk); #1 req_valid = 4'b1000;
        wait_grant(g);
        chk("mid_grant", g, 3);
        @(posedge clk); #1 req_valid = '0;
        wait_mix_en();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_mix_reset", mix_reset, 1);
        chk("mid_mix_en", mix_en, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        @(posedge clk); #1 req_valid = 4'b1001;
        wait_grant(g);
        chk("mid_regrant", g, 0);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp();
        @(negedge clk);

        // Two requesters back-to-back with full operand vectors
        set_slot(1, 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0,
                 128'ha5a5a5a5_5a5a5a5a_11223344_55667788, 128'h00000000_00000000_00000000_00000007,
                 128'hdead_beef);
        set_slot(2, 256'h1000, 128'h3, 128'h4, 128'h5);
        exp1 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0
             + 256'ha5a5a5a5_5a5a5a5a_11223344_55667788_00000000_00000000_00000000_00000007
             + 256'hdeadbeef + 256'd1;
        exp2 = 256'h3_00000000_00000000_00000000_00000004 + 256'h1000 + 256'h5 + 256'd1;
        @(posedge clk); #1 req_valid = 4'b0110;
        wait_grant(g);
        chk("mix_grant1", g, 1);
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_rsp();
        chk("mix_rsp_id1", rsp_id, 1);
        chk("mix_rsp_c1", rsp_c, exp1);
`ifdef MIX_SCHED_TIMEOUT_EN
        chk("mix_err1", rsp_err, 0);
`endif
        wait_grant(g);
        chk("mix_grant2", g, 2);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp();
        chk("mix_rsp_id2", rsp_id, 2);
        chk("mix_rsp_c2", rsp_c, exp2);
        @(negedge clk);

`ifdef MIX_SCHED_TIMEOUT_EN
        // Watchdog abort with an engine that never finishes
        @(posedge clk); #1 stub_hang = 1'b1; req_valid = 4'b0001;
        wait_grant(g);
        @(posedge clk); #1 req_valid = '0;
        wait_mix_en();
        lat = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); lat++;
            if (rsp_valid) break;
        end
        chk("to_latency", lat, 17);
        chk("to_err", rsp_err, 1);
        chk("to_rsp_c", rsp_c, 0);
        @(posedge clk); #1 stub_hang = 1'b0;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
